id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_pkg.sv | 69 ++++++
 rtl/id_stage_register_file.sv | 46 ++++
 rtl/id_stage.sv | 219 +++++++++++++++++++++
 tb/tb_id_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg -- shared definitions for the instruction-decode stage and its
// consumers (EX stage).
//   * RV32 opcode constants
//   * ALUOp / BranchType encodings carried in the control word
//   * ctrl_t : 16-bit packed control word
//   * id_ex_t: full ID/EX pipeline register contents
// No ports (package).
// -----------------------------------------------------------------------------
package id_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU operation class; EX refines R/I classes with funct3/funct7b5.
  // ALUOP_ADD is zero so that an all-zero control word is a harmless NOP.
  typedef enum logic [2:0] {
    ALUOP_ADD    = 3'd0,
    ALUOP_RTYPE  = 3'd1,
    ALUOP_ITYPE  = 3'd2,
    ALUOP_BRANCH = 3'd3,
    ALUOP_LUI    = 3'd4,
    ALUOP_AUIPC  = 3'd5
  } aluop_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_COND = 2'd1,
    BR_JAL  = 2'd2,
    BR_JALR = 2'd3
  } branch_e;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    ALUSrc;
    logic    MemtoReg;
    logic    PCtoReg;
    branch_e BranchType;
    aluop_e  ALUOp;
    logic [2:0] funct3;
    logic    funct7b5;
    logic    Jalr;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd;
    ctrl_t             ctrl;
  } id_ex_t;

endpackage

// File: rtl/id_stage_register_file.sv
// -----------------------------------------------------------------------------
// Register_File -- 32 x 32 architectural register file, 2 read / 1 write.
//   clk, rst_n        : clock, asynchronous active-low reset (clears all regs)
//   rs1_addr_i/rs2_.. : read addresses; data on rs1_data_o/rs2_data_o (comb.)
//   we_i, rd_i, wdata_i : write port, committed at posedge clk
// x0 always reads 0 and is never written. A read of the register being
// written in the same cycle returns the write data (writeback bypass).
// -----------------------------------------------------------------------------
module Register_File
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  // NOTE: this array carries an async reset because the architecture requires
  // every register to read 0 after reset; a plain RAM macro could not do this.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (rd_i != '0)) begin
      regs_q[rd_i] <= wdata_i;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
    if (addr == '0)                  return '0;
    else if (we_i && (rd_i == addr)) return wdata_i;
    else                             return regs_q[addr];
  endfunction

  assign rs1_data_o = read_port(rs1_addr_i);
  assign rs2_data_o = read_port(rs2_addr_i);

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage -- RV32I instruction decode stage with ID/EX pipeline register.
//   clk, rst          : clock, asynchronous active-low reset
//   IF_pc_out/IF_instr_out : contents of the IF/ID register (instr 0 = bubble)
//   InstrFlush        : EX resolved a taken branch/jump; squash this decode
//   WB_RegWrite/WB_rd/WB_wdata : register-file writeback port
//   PC_write          : 0 stalls the program counter (load-use hazard)
//   IFID_RegWrite     : 0 holds the IF/ID register (load-use hazard)
//   ID_*              : registered ID/EX fields, valid one cycle after IF_*
// -----------------------------------------------------------------------------
module id_stage
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   IF_pc_out,
  input  logic [XLEN-1:0]   IF_instr_out,
  input  logic              InstrFlush,
  input  logic              WB_RegWrite,
  input  logic [REG_AW-1:0] WB_rd,
  input  logic [XLEN-1:0]   WB_wdata,
  output logic              PC_write,
  output logic              IFID_RegWrite,
  output logic [XLEN-1:0]   ID_pc,
  output logic [XLEN-1:0]   ID_imm,
  output logic [XLEN-1:0]   ID_rs1_data,
  output logic [XLEN-1:0]   ID_rs2_data,
  output logic [REG_AW-1:0] ID_rs1_addr,
  output logic [REG_AW-1:0] ID_rs2_addr,
  output logic [REG_AW-1:0] ID_rd,
  output ctrl_t             ID_ctrl
);

  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1_addr;
  logic [REG_AW-1:0] rs2_addr;
  logic [REG_AW-1:0] rd_addr;

  assign instr    = IF_instr_out;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];

  // ---------------------------------------------------------------------------
  // Control decode and operand usage
  // ---------------------------------------------------------------------------
  ctrl_t ctrl_dec;
  logic  use_rs1;
  logic  use_rs2;

  // NOTE: every output of a combinational block gets a default before the case
  // so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    ctrl_dec = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_R: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_RTYPE;
        ctrl_dec.funct3   = funct3;
        ctrl_dec.funct7b5 = instr[30];
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_I: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_ITYPE;
        ctrl_dec.funct3   = funct3;
        // instr[30] is only an opcode bit for SRAI; elsewhere it is immediate.
        ctrl_dec.funct7b5 = (funct3 == 3'b101) ? instr[30] : 1'b0;
        use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.MemRead  = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.MemtoReg = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_ADD;
        ctrl_dec.funct3   = funct3;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_dec.MemWrite = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_ADD;
        ctrl_dec.funct3   = funct3;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_dec.BranchType = BR_COND;
        ctrl_dec.ALUOp      = ALUOP_BRANCH;
        ctrl_dec.funct3     = funct3;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        ctrl_dec.RegWrite   = 1'b1;
        ctrl_dec.PCtoReg    = 1'b1;
        ctrl_dec.BranchType = BR_JAL;
        ctrl_dec.ALUOp      = ALUOP_ADD;
      end
      OPC_JALR: begin
        ctrl_dec.RegWrite   = 1'b1;
        ctrl_dec.ALUSrc     = 1'b1;
        ctrl_dec.PCtoReg    = 1'b1;
        ctrl_dec.BranchType = BR_JALR;
        ctrl_dec.ALUOp      = ALUOP_ADD;
        ctrl_dec.funct3     = funct3;
        ctrl_dec.Jalr       = 1'b1;
        use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_LUI;
      end
      OPC_AUIPC: begin
        ctrl_dec.RegWrite = 1'b1;
        ctrl_dec.ALUSrc   = 1'b1;
        ctrl_dec.ALUOp    = ALUOP_AUIPC;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate generation
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] imm_dec;

  always_comb begin
    imm_dec = '0;
    case (opcode)
      OPC_I, OPC_LOAD, OPC_JALR:
        imm_dec = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm_dec = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm_dec = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_dec = {instr[31:12], 12'b0};
      OPC_JAL:
        imm_dec = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  Register_File u_register_file (
    .clk        (clk),
    .rst_n      (rst),
    .rs1_addr_i (rs1_addr),
    .rs2_addr_i (rs2_addr),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (WB_RegWrite),
    .rd_i       (WB_rd),
    .wdata_i    (WB_wdata)
  );

  // ---------------------------------------------------------------------------
  // Load-use hazard: the load now in ID/EX cannot forward its data in time to
  // the instruction in IF/ID, so hold IF/ID and the PC for one cycle and send
  // a bubble down. A flush wins: the dependent instruction is being discarded.
  // ---------------------------------------------------------------------------
  id_ex_t idex_d;
  id_ex_t idex_q;
  logic   load_use;
  logic   insert_bubble;

  assign load_use = idex_q.ctrl.MemRead && (idex_q.rd != '0) &&
                    ((use_rs1 && (idex_q.rd == rs1_addr)) ||
                     (use_rs2 && (idex_q.rd == rs2_addr)));

  assign insert_bubble = load_use || InstrFlush;
  assign PC_write      = !load_use || InstrFlush;
  assign IFID_RegWrite = !load_use || InstrFlush;

  always_comb begin
    idex_d = '0;
    if (!insert_bubble) begin
      idex_d.pc       = IF_pc_out;
      idex_d.imm      = imm_dec;
      idex_d.rs1_data = rs1_data;
      idex_d.rs2_data = rs2_data;
      idex_d.rs1_addr = rs1_addr;
      idex_d.rs2_addr = rs2_addr;
      idex_d.rd       = rd_addr;
      idex_d.ctrl     = ctrl_dec;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign ID_pc       = idex_q.pc;
  assign ID_imm      = idex_q.imm;
  assign ID_rs1_data = idex_q.rs1_data;
  assign ID_rs2_data = idex_q.rs2_data;
  assign ID_rs1_addr = idex_q.rs1_addr;
  assign ID_rs2_addr = idex_q.rs2_addr;
  assign ID_rd       = idex_q.rd;
  assign ID_ctrl     = idex_q.ctrl;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage -- self-checking bench for id_stage.
// Expected ID/EX contents are queued when an instruction is presented and
// popped/compared one rising edge later.
// -----------------------------------------------------------------------------
module tb_id_stage;
  import id_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] IF_pc_out = '0;
  logic [31:0] IF_instr_out = '0;
  logic        InstrFlush = 1'b0;
  logic        WB_RegWrite = 1'b0;
  logic [4:0]  WB_rd = '0;
  logic [31:0] WB_wdata = '0;
  logic        PC_write;
  logic        IFID_RegWrite;
  logic [31:0] ID_pc, ID_imm, ID_rs1_data, ID_rs2_data;
  logic [4:0]  ID_rs1_addr, ID_rs2_addr, ID_rd;
  ctrl_t       ID_ctrl;

  always #5 clk = ~clk;

  id_stage dut (
    .clk           (clk),
    .rst           (rst),
    .IF_pc_out     (IF_pc_out),
    .IF_instr_out  (IF_instr_out),
    .InstrFlush    (InstrFlush),
    .WB_RegWrite   (WB_RegWrite),
    .WB_rd         (WB_rd),
    .WB_wdata      (WB_wdata),
    .PC_write      (PC_write),
    .IFID_RegWrite (IFID_RegWrite),
    .ID_pc         (ID_pc),
    .ID_imm        (ID_imm),
    .ID_rs1_data   (ID_rs1_data),
    .ID_rs2_data   (ID_rs2_data),
    .ID_rs1_addr   (ID_rs1_addr),
    .ID_rs2_addr   (ID_rs2_addr),
    .ID_rd         (ID_rd),
    .ID_ctrl       (ID_ctrl)
  );

  typedef struct {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        exp;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic ctrl_t mk_ctrl(input logic rw, input logic mr, input logic mw,
                                    input logic as, input logic m2r, input logic p2r,
                                    input branch_e bt, input aluop_e op,
                                    input logic [2:0] f3, input logic f7, input logic jr);
    ctrl_t c;
    c.RegWrite = rw; c.MemRead = mr; c.MemWrite = mw; c.ALUSrc = as;
    c.MemtoReg = m2r; c.PCtoReg = p2r; c.BranchType = bt; c.ALUOp = op;
    c.funct3 = f3; c.funct7b5 = f7; c.Jalr = jr;
    return c;
  endfunction

  function automatic exp_t mk_exp(input ctrl_t c, input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [4:0] rd, input logic [4:0] rs1a, input logic [4:0] rs2a,
                                  input logic [31:0] rs1d, input logic [31:0] rs2d);
    exp_t e;
    e.ctrl = c; e.pc = pc; e.imm = imm; e.rd = rd;
    e.rs1a = rs1a; e.rs2a = rs2a; e.rs1d = rs1d; e.rs2d = rs2d;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [31:0] instr, input exp_t e);
    vec_t v;
    v.instr = instr;
    v.exp   = e;
    return v;
  endfunction

  function automatic exp_t bubble();
    return mk_exp('0, '0, '0, '0, '0, '0, '0, '0);
  endfunction

  // Wait for the capturing edge, then compare ID/EX against the oldest entry.
  task automatic clock_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_ctrl"}, {16'h0, ID_ctrl}, {16'h0, e.ctrl});
      check({tag, "_pc"},   ID_pc,  e.pc);
      check({tag, "_imm"},  ID_imm, e.imm);
      check({tag, "_rd"},   {27'h0, ID_rd},       {27'h0, e.rd});
      check({tag, "_rs1a"}, {27'h0, ID_rs1_addr}, {27'h0, e.rs1a});
      check({tag, "_rs2a"}, {27'h0, ID_rs2_addr}, {27'h0, e.rs2a});
      check({tag, "_rs1d"}, ID_rs1_data, e.rs1d);
      check({tag, "_rs2d"}, ID_rs2_data, e.rs2d);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    IF_instr_out = instr;
    IF_pc_out    = pc;
  endtask

  task automatic check_stall(input string tag, input logic exp_run);
    check({tag, "_PC_write"},      {31'h0, PC_write},      {31'h0, exp_run});
    check({tag, "_IFID_RegWrite"}, {31'h0, IFID_RegWrite}, {31'h0, exp_run});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ctrl_t c_lw, c_add, c_lui;

    c_lw  = mk_ctrl(1, 1, 0, 1, 1, 0, BR_NONE, ALUOP_ADD,   3'd2, 0, 0);
    c_add = mk_ctrl(1, 0, 0, 0, 0, 0, BR_NONE, ALUOP_RTYPE, 3'd0, 0, 0);
    c_lui = mk_ctrl(1, 0, 0, 1, 0, 0, BR_NONE, ALUOP_LUI,   3'd0, 0, 0);

    // ---------------------------------------------------------------- vectors
    vecs.push_back(mk_vec(32'hFFF00293, mk_exp(  // ADDI x5,x0,-1
      mk_ctrl(1,0,0,1,0,0,BR_NONE,ALUOP_ITYPE,3'd0,0,0), 32'h40, 32'hFFFFFFFF, 5, 0, 31, 0, 0)));
    vecs.push_back(mk_vec(32'h00038433, mk_exp(  // ADD x8,x7,x0
      c_add, 32'h44, 32'h0, 8, 7, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h402081B3, mk_exp(  // SUB x3,x1,x2
      mk_ctrl(1,0,0,0,0,0,BR_NONE,ALUOP_RTYPE,3'd0,1,0), 32'h48, 32'h0, 3, 1, 2, 0, 0)));
    vecs.push_back(mk_vec(32'hFE512E23, mk_exp(  // SW x5,-4(x2)
      mk_ctrl(0,0,1,1,0,0,BR_NONE,ALUOP_ADD,3'd2,0,0), 32'h4C, 32'hFFFFFFFC, 28, 2, 5, 0, 0)));
    vecs.push_back(mk_vec(32'hFE208CE3, mk_exp(  // BEQ x1,x2,-8
      mk_ctrl(0,0,0,0,0,0,BR_COND,ALUOP_BRANCH,3'd0,0,0), 32'h50, 32'hFFFFFFF8, 25, 1, 2, 0, 0)));
    vecs.push_back(mk_vec(32'h001000EF, mk_exp(  // JAL x1,+2048
      mk_ctrl(1,0,0,0,0,1,BR_JAL,ALUOP_ADD,3'd0,0,0), 32'h54, 32'h00000800, 1, 0, 1, 0, 0)));
    vecs.push_back(mk_vec(32'hFFDFF06F, mk_exp(  // JAL x0,-4
      mk_ctrl(1,0,0,0,0,1,BR_JAL,ALUOP_ADD,3'd0,0,0), 32'h58, 32'hFFFFFFFC, 0, 31, 29, 0, 0)));
    vecs.push_back(mk_vec(32'h004280E7, mk_exp(  // JALR x1,4(x5)
      mk_ctrl(1,0,0,1,0,1,BR_JALR,ALUOP_ADD,3'd0,0,1), 32'h5C, 32'h4, 1, 5, 4, 0, 0)));
    vecs.push_back(mk_vec(32'h12345537, mk_exp(  // LUI x10,0x12345
      c_lui, 32'h60, 32'h12345000, 10, 8, 3, 0, 0)));
    vecs.push_back(mk_vec(32'hFFFFF197, mk_exp(  // AUIPC x3,0xFFFFF
      mk_ctrl(1,0,0,1,0,0,BR_NONE,ALUOP_AUIPC,3'd0,0,0), 32'h64, 32'hFFFFF000, 3, 31, 31, 0, 0)));
    vecs.push_back(mk_vec(32'h40325213, mk_exp(  // SRAI x4,x4,3
      mk_ctrl(1,0,0,1,0,0,BR_NONE,ALUOP_ITYPE,3'd5,1,0), 32'h68, 32'h403, 4, 4, 3, 0, 0)));
    vecs.push_back(mk_vec(32'h00012303, mk_exp(  // LW x6,0(x2)
      c_lw, 32'h6C, 32'h0, 6, 2, 0, 0, 0)));
    vecs.push_back(mk_vec(32'h00000000, mk_exp(  // flushed bubble
      '0, 32'h70, 32'h0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk_vec(32'hFFFFFFFF, mk_exp(  // illegal opcode -> NOP ctrl
      '0, 32'h74, 32'h0, 31, 31, 31, 0, 0)));

    // ------------------------------------------------------------------ reset
    #2 rst = 1'b0;
    #1;
    check("rst_ctrl", {16'h0, ID_ctrl}, 32'h0);
    check("rst_pc", ID_pc, 32'h0);
    check_stall("rst", 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // ---------------------------------------------------------- table vectors
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      present(vecs[i].instr, vecs[i].exp.pc);
      #1;
      check_stall($sformatf("vec%0d", i), 1'b1);
      sb.push_back(vecs[i].exp);
      clock_check($sformatf("vec%0d", i));
    end

    // --------------------------------------------------------------- bypass
    @(negedge clk);
    WB_RegWrite = 1'b1; WB_rd = 5'd7; WB_wdata = 32'hDEADBEEF;
    present(32'h00038433, 32'h80);                     // ADD x8,x7,x0
    sb.push_back(mk_exp(c_add, 32'h80, 0, 8, 7, 0, 32'hDEADBEEF, 0));
    clock_check("bypass_x7");
    @(negedge clk);
    WB_RegWrite = 1'b0;
    sb.push_back(mk_exp(c_add, 32'h80, 0, 8, 7, 0, 32'hDEADBEEF, 0));
    clock_check("stored_x7");
    @(negedge clk);
    WB_RegWrite = 1'b1; WB_rd = 5'd0; WB_wdata = 32'h12345678;
    present(32'h00000433, 32'h84);                     // ADD x8,x0,x0
    sb.push_back(mk_exp(c_add, 32'h84, 0, 8, 0, 0, 0, 0));
    clock_check("bypass_x0");
    @(negedge clk);
    WB_RegWrite = 1'b0;
    sb.push_back(mk_exp(c_add, 32'h84, 0, 8, 0, 0, 0, 0));
    clock_check("stored_x0");

    // ------------------------------------------------------------- load-use
    @(negedge clk);
    present(32'h00012303, 32'h100);                    // LW x6,0(x2)
    sb.push_back(mk_exp(c_lw, 32'h100, 0, 6, 2, 0, 0, 0));
    clock_check("lu_lw");
    @(negedge clk);
    present(32'h001304B3, 32'h104);                    // ADD x9,x6,x1
    #1;
    check_stall("lu_stall", 1'b0);
    sb.push_back(bubble());
    clock_check("lu_bubble");
    @(negedge clk);                                    // IF/ID held
    check_stall("lu_resume", 1'b1);
    sb.push_back(mk_exp(c_add, 32'h104, 0, 9, 6, 1, 0, 0));
    clock_check("lu_add");

    // --------------------------------------------------- load-use with flush
    @(negedge clk);
    present(32'h00012303, 32'h200);
    sb.push_back(mk_exp(c_lw, 32'h200, 0, 6, 2, 0, 0, 0));
    clock_check("fl_lw");
    @(negedge clk);
    present(32'h001304B3, 32'h204);
    #1;
    check_stall("fl_hazard", 1'b0);
    InstrFlush = 1'b1;
    #1;
    check_stall("fl_flush", 1'b1);
    sb.push_back(bubble());
    clock_check("fl_bubble");
    @(negedge clk);
    InstrFlush = 1'b0;

    // ------------------------------------------------------ no-stall cases
    present(32'h00012003, 32'h300);                    // LW x0,0(x2)
    sb.push_back(mk_exp(c_lw, 32'h300, 0, 0, 2, 0, 0, 0));
    clock_check("ns_lw_x0");
    @(negedge clk);
    present(32'h000004B3, 32'h304);                    // ADD x9,x0,x0
    #1;
    check_stall("ns_add_x0", 1'b1);
    sb.push_back(mk_exp(c_add, 32'h304, 0, 9, 0, 0, 0, 0));
    clock_check("ns_add_x0");
    @(negedge clk);
    present(32'h00012303, 32'h308);                    // LW x6,0(x2)
    sb.push_back(mk_exp(c_lw, 32'h308, 0, 6, 2, 0, 0, 0));
    clock_check("ns_lw_x6");
    @(negedge clk);
    present(32'h00030337, 32'h30C);                    // LUI x6,0x30 (rs1 field=6)
    #1;
    check_stall("ns_lui", 1'b1);
    sb.push_back(mk_exp(c_lui, 32'h30C, 32'h00030000, 6, 6, 0, 0, 0));
    clock_check("ns_lui");

    // ------------------------------------- fill regs, reset mid-stall, readback
    present(32'h0, 32'h0);
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      WB_RegWrite = 1'b1; WB_rd = 5'(r); WB_wdata = 32'h01010101 * r;
      @(posedge clk);
    end
    @(negedge clk);
    WB_RegWrite = 1'b0;
    present(32'h01EF8033, 32'h400);                    // ADD x0,x31,x30
    sb.push_back(mk_exp(c_add, 32'h400, 0, 0, 31, 30, 32'h1F1F1F1F, 32'h1E1E1E1E));
    clock_check("fill_read");
    @(negedge clk);
    present(32'h00012303, 32'h404);
    sb.push_back(mk_exp(c_lw, 32'h404, 0, 6, 2, 0, 32'h02020202, 0));
    clock_check("mr_lw");
    @(negedge clk);
    present(32'h001304B3, 32'h408);
    #1;
    check_stall("mr_stall", 1'b0);
    #1 rst = 1'b0;
    #1;
    check_stall("mr_in_reset", 1'b1);
    check("mr_ctrl", {16'h0, ID_ctrl}, 32'h0);
    check("mr_pc", ID_pc, 32'h0);
    check("mr_rd", {27'h0, ID_rd}, 32'h0);
    check("mr_rs1d", ID_rs1_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int r = 1; r < 32; r++) begin
      if (r != 1) @(negedge clk);
      present((32'(r) << 20) | (32'(r) << 15) | 32'h33, 32'h500 + 32'(4 * r));
      sb.push_back(mk_exp(c_add, 32'h500 + 32'(4 * r), 0, 0, 5'(r), 5'(r), 0, 0));
      clock_check($sformatf("post_rst_x%0d", r));
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
